// File: rtl/ssd_scan_driver_if.sv
// ssd_scan_driver_if: display value/control inputs and scan outputs of the seven-segment driver.
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    blank_lz;
  logic                    load;
  logic [3:0]              brightness;
  logic [NUM_DIGITS-1:0]   anodes;
  logic [7:0]              cathodes;
  logic [IW-1:0]           digit_idx;
  logic                    frame_done;
  modport master (
    output value, dp_mask, digit_en, blank_lz, load, brightness,
    input  anodes, cathodes, digit_idx, frame_done
  );
  modport slave (
    input  value, dp_mask, digit_en, blank_lz, load, brightness,
    output anodes, cathodes, digit_idx, frame_done
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed seven-segment scanner with double-buffered value and leading-zero blanking.
// Define SSD_DIM_EN to gate anodes with a 16-step brightness PWM (needs PRESCALE_BITS >= 4).
module ssd_scan_driver #(
  parameter int NUM_DIGITS    = 8,
  parameter int PRESCALE_BITS = 18,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input logic               ClkPort,
  input logic               Reset,
  ssd_scan_driver_if.slave  bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  // Active-low abcdefg patterns for hex 0..F
  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [PRESCALE_BITS-1:0] r_pre;
  logic [IW-1:0]            r_idx;
  logic                     r_frame_done;
  logic                     r_pend_valid;
  logic [4*NUM_DIGITS-1:0]  r_act_val;
  logic [4*NUM_DIGITS-1:0]  r_pend_val;
  logic [NUM_DIGITS-1:0]    r_act_dp;
  logic [NUM_DIGITS-1:0]    r_pend_dp;
  logic [NUM_DIGITS-1:0]    r_an;
  logic [7:0]               r_seg;
  logic                     w_tick;
  logic                     w_wrap;
  logic                     w_zero;
  logic                     w_gate;
  logic [NUM_DIGITS-1:0]    w_blank;
  logic [3:0]               w_nib;
  assign w_tick = &r_pre;
  assign w_wrap = w_tick && (r_idx == IW'(NUM_DIGITS - 1));
  assign w_nib  = 4'(r_act_val >> {r_idx, 2'b00});
`ifdef SSD_DIM_EN
  assign w_gate = r_pre[PRESCALE_BITS-1 -: 4] <= bus.brightness;
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^bus.brightness;
  assign w_gate = 1'b1;
`endif
  // w_zero accumulates "this nibble and every higher one are zero" from the top down
  always_comb begin
    w_zero  = 1'b1;
    w_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero     = w_zero && (r_act_val[4*i +: 4] == 4'd0);
      w_blank[i] = !bus.digit_en[i] || (bus.blank_lz && i > 0 && w_zero);
    end
  end
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      r_pre        <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
      r_pend_valid <= 1'b0;
      r_act_val    <= '0;
      r_pend_val   <= '0;
      r_act_dp     <= '0;
      r_pend_dp    <= '0;
      r_an         <= '0;
      r_seg        <= '0;
    end else begin
      r_pre        <= r_pre + 1'b1;
      r_frame_done <= w_wrap;
      if (w_tick)
        r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      if (bus.load && w_wrap) begin
        r_act_val    <= bus.value;
        r_act_dp     <= bus.dp_mask;
        r_pend_valid <= 1'b0;
      end else if (bus.load) begin
        r_pend_val   <= bus.value;
        r_pend_dp    <= bus.dp_mask;
        r_pend_valid <= 1'b1;
      end else if (w_wrap && r_pend_valid) begin
        r_act_val    <= r_pend_val;
        r_act_dp     <= r_pend_dp;
        r_pend_valid <= 1'b0;
      end
      r_an  <= (w_blank[r_idx] || !w_gate) ? '0 : NUM_DIGITS'(1) << r_idx;
      r_seg <= w_blank[r_idx] ? '0 : {~SEG[w_nib], r_act_dp[r_idx]};
    end
  end
  assign bus.anodes     = ACTIVE_LOW ? ~r_an : r_an;
  assign bus.cathodes   = ACTIVE_LOW ? ~r_seg : r_seg;
  assign bus.digit_idx  = r_idx;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: scoreboard bench; expected frames are queued at each load and checked slot by slot.
module tb_ssd_scan_driver;
  localparam int N = 8;
`ifdef SSD_DIM_EN
  localparam int P = 6;
`else
  localparam int P = 2;
`endif
  localparam int S = 1 << P;
  localparam logic [6:0] SEGT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] an;
    logic [7:0] cat;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  ent_t sb[$];
  logic [31:0] cur_val = '0;
  logic [7:0]  cur_dp = '0;
  ssd_scan_driver_if #(.NUM_DIGITS(N)) bus ();
  ssd_scan_driver #(.NUM_DIGITS(N), .PRESCALE_BITS(P), .ACTIVE_LOW(1'b1)) dut (
    .ClkPort(clk),
    .Reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push_frame();
    ent_t e;
    logic b;
    for (int k = 0; k < N; k++) begin
      b = !bus.digit_en[k] || (bus.blank_lz && k > 0 && (cur_val >> (4 * k)) == 32'd0);
      e.idx = 3'(k);
      e.an  = b ? 8'hFF : ~(8'h01 << k);
      e.cat = b ? 8'hFF : {SEGT[cur_val[4*k +: 4]], ~cur_dp[k]};
      sb.push_back(e);
    end
  endtask
  task automatic wait_wrap();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_done !== 1'b1 && n < 2 * N * S + 4);
    if (bus.frame_done !== 1'b1) chk("wrap_timeout", 32'd0, 32'd1);
  endtask
  task automatic sample_frame(input string tag);
    ent_t e;
    for (int k = 0; k < N; k++) begin
      repeat (k == 0 ? 2 : S) @(negedge clk);
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("%s_idx%0d", tag, k), 32'(bus.digit_idx), 32'(e.idx));
        chk($sformatf("%s_an%0d", tag, k), 32'(bus.anodes), 32'(e.an));
        chk($sformatf("%s_cat%0d", tag, k), 32'(bus.cathodes), 32'(e.cat));
      end
    end
  endtask
  task automatic do_load(input logic [31:0] v, input logic [7:0] d);
    bus.value   = v;
    bus.dp_mask = d;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask
  task automatic load_frame(input string tag, input logic [31:0] v, input logic [7:0] d);
    wait_wrap();
    do_load(v, d);
    cur_val = v;
    cur_dp  = d;
    push_frame();
    wait_wrap();
    sample_frame(tag);
  endtask
  task automatic measure(input int k, output int an_cnt, output int fd_cnt, output int fd_pos);
    an_cnt = 0;
    fd_cnt = 0;
    fd_pos = 0;
    wait_wrap();
    for (int c = 1; c <= N * S; c++) begin
      @(negedge clk);
      if (bus.anodes[k] === 1'b0) an_cnt++;
      if (bus.frame_done === 1'b1) begin
        fd_cnt++;
        fd_pos = c;
      end
    end
  endtask
  initial begin
    int an_cnt, fd_cnt, fd_pos;
    bus.value = '0;
    bus.dp_mask = '0;
    bus.digit_en = 8'hFF;
    bus.blank_lz = 1'b0;
    bus.load = 1'b0;
    bus.brightness = 4'd15;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(bus.anodes), 32'hFF);
    chk("rst_cat", 32'(bus.cathodes), 32'hFF);
    rst = 1'b0;
    push_frame();
    wait_wrap();
    sample_frame("zeros");
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", 32'(bus.anodes), 32'hFF);
    chk("midrst_cat", 32'(bus.cathodes), 32'hFF);
    chk("midrst_idx", 32'(bus.digit_idx), 32'd0);
    chk("midrst_fd", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;
    bus.blank_lz = 1'b1;
    load_frame("v1234", 32'h0000_1234, 8'h00);
    wait_wrap();
    do_load(32'hAAAA_0005, 8'h0F);
    repeat (5) @(negedge clk);
    do_load(32'h00B0_0C0D, 8'h22);
    cur_val = 32'h00B0_0C0D;
    cur_dp  = 8'h22;
    push_frame();
    wait_wrap();
    sample_frame("lastwins");
    wait_wrap();
    repeat (N * S - 1) @(negedge clk);
    bus.value   = 32'hFEDC_BA98;
    bus.dp_mask = 8'h80;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
    chk("coinc_fd", 32'(bus.frame_done), 32'd1);
    cur_val = 32'hFEDC_BA98;
    cur_dp  = 8'h80;
    push_frame();
    sample_frame("coinc");
    push_frame();
    wait_wrap();
    sample_frame("coinc_hold");
    load_frame("zero_lz", 32'h0, 8'h00);
    load_frame("zero_dp", 32'h0, 8'h01);
    bus.blank_lz = 1'b0;
    bus.digit_en = 8'b1111_0111;
    load_frame("en_f7", 32'h1234_5678, 8'h00);
    measure(3, an_cnt, fd_cnt, fd_pos);
    chk("an3_count", 32'(an_cnt), 32'd0);
    chk("fd_count", 32'(fd_cnt), 32'd1);
    chk("fd_period", 32'(fd_pos), 32'(N * S));
    @(negedge clk);
    chk("fd_width", 32'(bus.frame_done), 32'd0);
    bus.digit_en = 8'hFF;
    bus.brightness = 4'd3;
    measure(0, an_cnt, fd_cnt, fd_pos);
`ifdef SSD_DIM_EN
    chk("dim3", 32'(an_cnt), 32'(4 * S / 16));
`else
    chk("dim3_ignored", 32'(an_cnt), 32'(S));
`endif
    bus.brightness = 4'd15;
    measure(0, an_cnt, fd_cnt, fd_pos);
    chk("dim15", 32'(an_cnt), 32'(S));
    bus.brightness = 4'd0;
    measure(5, an_cnt, fd_cnt, fd_pos);
`ifdef SSD_DIM_EN
    chk("dim0", 32'(an_cnt), 32'(S / 16));
`else
    chk("dim0_ignored", 32'(an_cnt), 32'(S));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
